// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for the three-stage RV32I core.
// Owns the fetch PC, issues one-outstanding requests to instruction memory,
// buffers fetched words with their PCs in a 2-entry FIFO toward decode, and
// handles redirects (flush, restart, misaligned-target trap).
module fetch_ctrl #(
  parameter logic [31:0] RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_mem_is_ready,
  output logic [31:0] inst_mem_addr,
  input  logic        inst_mem_is_valid,
  input  logic [31:0] inst_mem_read_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  output logic        exception
);

  typedef enum logic [1:0] {IDLE, REQ, DROP, HALT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pend_pc;
  logic [31:0] fifo_pc   [2];
  logic [31:0] fifo_inst [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  logic rsp, pop, push, redir, misalign, credit_idle, credit_push;

  // A response only counts while a request is actually outstanding.
  assign rsp      = inst_mem_is_valid & ((state == REQ) | (state == DROP));
  assign pop      = dec_valid & dec_ready;
  assign push     = rsp & (state == REQ);
  // Once trapped, further redirects are ignored until reset.
  assign redir    = redirect_valid & ~exception & (state != HALT);
  assign misalign = redirect_pc[1:0] != 2'b00;

  // Credit: next-cycle occupancy (count + push - pop) must stay below 2.
  assign credit_idle = (count != 2'd2) | pop;
  assign credit_push = count == {1'b0, pop};

  assign inst_mem_is_ready = (state == REQ) | (state == DROP);
  assign inst_mem_addr     = pc;
  assign dec_valid         = count != 2'd0;
  assign dec_inst          = fifo_inst[rd_ptr];
  assign dec_pc            = fifo_pc[rd_ptr];

  // Fetch sequencer, FIFO bookkeeping and trap handling.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= RESET;
      pend_pc   <= RESET;
      count     <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      exception <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_pc[i]   <= 32'h0;
        fifo_inst[i] <= 32'h0;
      end
    end else if (redir) begin
      // Redirect wins over everything: flush, and any head handshake is moot.
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      if (misalign) begin
        exception <= 1'b1;
        // An in-flight request must finish (and be dropped) before halting.
        state <= ((state == IDLE) | rsp) ? HALT : DROP;
      end else if (state == IDLE || rsp) begin
        pc    <= redirect_pc;
        state <= REQ;
      end else begin
        pend_pc <= redirect_pc;
        state   <= DROP;
      end
    end else begin
      if (pop) rd_ptr <= ~rd_ptr;
      if (push) begin
        fifo_pc[wr_ptr]   <= pc;
        fifo_inst[wr_ptr] <= inst_mem_read_data;
        wr_ptr            <= ~wr_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
      case (state)
        IDLE: if (credit_idle) state <= REQ;
        REQ: if (rsp) begin
          pc    <= pc + 32'd4;
          state <= credit_push ? REQ : IDLE;
        end
        DROP: if (rsp) begin
          if (exception) state <= HALT;
          else begin
            pc    <= pend_pc;
            state <= REQ;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
